piece_ctrl: RTL and testbench

- Parametrised active-piece controller for the Tetris game.
- Owns the falling piece state (anchor x/y, type, dir), applies gravity and user moves, and spawns new pieces.
- Validates every candidate position through a request/response collision-check port to the board block.
- Emits a lock pulse when the piece lands and a game-over flag when a spawn collides.

---
 rtl/piece_pkg.sv | 44 ++++
 rtl/gravity_timer.sv | 53 +++++
 rtl/piece_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_piece_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// Shared definitions for the active-piece controller: FSM states, action codes, piece types.
// PIECE_WALLKICK_EN adds the KICK_L/KICK_R rotation retry states.
package piece_pkg;

`ifdef PIECE_WALLKICK_EN
    typedef enum logic [3:0] {
        IDLE, SPAWN_CHK, READY, MOVE_CHK, HARD_CHK, LOCK, OVER, KICK_L, KICK_R
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, SPAWN_CHK, READY, MOVE_CHK, HARD_CHK, LOCK, OVER
    } state_e;
`endif

    typedef enum logic [2:0] {ACT_ROT, ACT_L, ACT_R, ACT_DN, ACT_HD} act_e;

    localparam logic [2:0] I = 3'd0;
    localparam logic [2:0] O = 3'd1;
    localparam logic [2:0] T = 3'd2;
    localparam logic [2:0] S = 3'd3;
    localparam logic [2:0] Z = 3'd4;
    localparam logic [2:0] J = 3'd5;
    localparam logic [2:0] L = 3'd6;

    // States in which a candidate is presented on the check port.
    function automatic logic in_check(input state_e s);
        logic r;
        r = 1'b0;
        case (s)
            SPAWN_CHK, MOVE_CHK, HARD_CHK: r = 1'b1;
`ifdef PIECE_WALLKICK_EN
            KICK_L, KICK_R: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Out-of-range type codes fall back to the I piece.
    function automatic logic [2:0] legal_type(input logic [2:0] t);
        return (t > L) ? I : t;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity step generator: counts GRAV_DIV enabled cycles, then raises a sticky pend flag.
// A tick coinciding with ack keeps pend set so no step is lost.
module gravity_timer #(
    parameter int unsigned GRAV_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic ack,
    output logic pend
);

    localparam int unsigned CW = $clog2(GRAV_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          tick;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        tick   = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (en) begin
                if (cnt_q == CW'(GRAV_DIV - 1)) begin
                    cnt_d = '0;
                    tick  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (ack) pend_d = 1'b0;
            if (tick) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: gravity, user moves, hard drop and spawn, each validated by the board.
// Define PIECE_WALLKICK_EN to retry failed rotations one column left, then right.
module piece_ctrl
    import piece_pkg::*;
#(
    parameter int unsigned BOARD_W  = 10,
    parameter int unsigned BOARD_H  = 20,
    parameter int unsigned XW       = 5,
    parameter int unsigned YW       = 5,
    parameter int unsigned GRAV_DIV = 25000000,
    parameter int unsigned SPAWN_X  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          drop,
    input  logic [2:0]    next_type,
    output logic          chk_valid,
    output logic [XW-1:0] chk_x,
    output logic [YW-1:0] chk_y,
    output logic [2:0]    chk_type,
    output logic [1:0]    chk_dir,
    input  logic          chk_ready,
    input  logic          chk_ok,
    output logic          lock_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    ptype,
    output logic [1:0]    dir,
    output logic          game_over,
    output logic          busy
);

    state_e        state_q, state_d;
    act_e          act_q, act_d;
    logic [XW-1:0] x_q, x_d, cand_x_q, cand_x_d;
    logic [YW-1:0] y_q, y_d, cand_y_q, cand_y_d;
    logic [2:0]    ptype_q, ptype_d, cand_type_q, cand_type_d;
    logic [1:0]    dir_q, dir_d, cand_dir_q, cand_dir_d;

    logic at_left, at_right, at_bottom;
    logic grav_en, grav_clr, grav_ack, grav_pend;
    logic spawn_entry;

    assign at_left   = (x_q == '0);
    assign at_right  = (x_q == XW'(BOARD_W - 1));
    assign at_bottom = (y_q == YW'(BOARD_H - 1));

    gravity_timer #(
        .GRAV_DIV(GRAV_DIV)
    ) u_grav (
        .clk (clk),
        .rst (rst),
        .en  (grav_en),
        .clr (grav_clr),
        .ack (grav_ack),
        .pend(grav_pend)
    );

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        x_d         = x_q;
        y_d         = y_q;
        ptype_d     = ptype_q;
        dir_d       = dir_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        cand_type_d = cand_type_q;
        cand_dir_d  = cand_dir_q;
        grav_ack    = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) state_d = SPAWN_CHK;
            end

            SPAWN_CHK: begin
                if (chk_ready) begin
                    if (chk_ok) begin
                        x_d     = cand_x_q;
                        y_d     = cand_y_q;
                        ptype_d = cand_type_q;
                        dir_d   = cand_dir_q;
                        state_d = READY;
                    end else begin
                        state_d = OVER;
                    end
                end
            end

            READY: begin
                cand_x_d    = x_q;
                cand_y_d    = y_q;
                cand_type_d = ptype_q;
                cand_dir_d  = dir_q;
                // One action per cycle; a rejected move still consumes the cycle.
                if (drop) begin
                    act_d = ACT_HD;
                    if (at_bottom) begin
                        state_d = LOCK;
                    end else begin
                        cand_y_d = y_q + YW'(1);
                        state_d  = HARD_CHK;
                    end
                end else if (up) begin
                    act_d      = ACT_ROT;
                    cand_dir_d = dir_q + 2'd1;
                    state_d    = MOVE_CHK;
                end else if (left) begin
                    if (!at_left) begin
                        act_d    = ACT_L;
                        cand_x_d = x_q - XW'(1);
                        state_d  = MOVE_CHK;
                    end
                end else if (right) begin
                    if (!at_right) begin
                        act_d    = ACT_R;
                        cand_x_d = x_q + XW'(1);
                        state_d  = MOVE_CHK;
                    end
                end else if (down || grav_pend) begin
                    act_d    = ACT_DN;
                    grav_ack = 1'b1;
                    if (at_bottom) begin
                        state_d = LOCK;
                    end else begin
                        cand_y_d = y_q + YW'(1);
                        state_d  = MOVE_CHK;
                    end
                end
            end

            MOVE_CHK: begin
                if (chk_ready) begin
                    if (chk_ok) begin
                        x_d     = cand_x_q;
                        y_d     = cand_y_q;
                        dir_d   = cand_dir_q;
                        state_d = READY;
                    end else if (act_q == ACT_DN) begin
                        state_d = LOCK;
`ifdef PIECE_WALLKICK_EN
                    end else if (act_q == ACT_ROT && !at_left) begin
                        cand_x_d = x_q - XW'(1);
                        state_d  = KICK_L;
                    end else if (act_q == ACT_ROT && !at_right) begin
                        cand_x_d = x_q + XW'(1);
                        state_d  = KICK_R;
`endif
                    end else begin
                        state_d = READY;
                    end
                end
            end

            HARD_CHK: begin
                if (chk_ready) begin
                    if (chk_ok) begin
                        y_d = cand_y_q;
                        if (cand_y_q == YW'(BOARD_H - 1)) begin
                            state_d = LOCK;
                        end else begin
                            cand_y_d = cand_y_q + YW'(1);
                        end
                    end else begin
                        state_d = LOCK;
                    end
                end
            end

            LOCK: begin
                state_d = SPAWN_CHK;
            end

`ifdef PIECE_WALLKICK_EN
            KICK_L: begin
                if (chk_ready) begin
                    if (chk_ok) begin
                        x_d     = cand_x_q;
                        dir_d   = cand_dir_q;
                        state_d = READY;
                    end else if (!at_right) begin
                        cand_x_d = x_q + XW'(1);
                        state_d  = KICK_R;
                    end else begin
                        state_d = READY;
                    end
                end
            end

            KICK_R: begin
                if (chk_ready) begin
                    if (chk_ok) begin
                        x_d   = cand_x_q;
                        dir_d = cand_dir_q;
                    end
                    state_d = READY;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        // next_type is captured once, on the way into the spawn check.
        if (spawn_entry) begin
            cand_x_d    = XW'(SPAWN_X);
            cand_y_d    = '0;
            cand_type_d = legal_type(next_type);
            cand_dir_d  = '0;
        end
    end

    assign spawn_entry = (state_d == SPAWN_CHK) && (state_q != SPAWN_CHK);
    assign grav_clr    = spawn_entry;
    assign grav_en     = (state_q == READY) || (in_check(state_q) && state_q != SPAWN_CHK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= ACT_ROT;
            x_q         <= '0;
            y_q         <= '0;
            ptype_q     <= '0;
            dir_q       <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            cand_type_q <= '0;
            cand_dir_q  <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ptype_q     <= ptype_d;
            dir_q       <= dir_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            cand_type_q <= cand_type_d;
            cand_dir_q  <= cand_dir_d;
        end
    end

    assign chk_valid  = in_check(state_q);
    assign chk_x      = cand_x_q;
    assign chk_y      = cand_y_q;
    assign chk_type   = cand_type_q;
    assign chk_dir    = cand_dir_q;
    assign lock_valid = (state_q == LOCK);
    assign x          = x_q;
    assign y          = y_q;
    assign ptype      = ptype_q;
    assign dir        = dir_q;
    assign game_over  = (state_q == OVER);
    assign busy       = !(state_q == IDLE || state_q == READY || state_q == OVER);

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: a slow-gravity instance driven by a scripted board and a
// fast-gravity (GRAV_DIV=4) instance with an always-free board.
module tb_piece_ctrl;

    localparam int unsigned XW = 5;
    localparam int unsigned YW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, up, down, left, right, drop;
    logic [2:0]    next_type;
    logic          chk_valid, chk_ready, chk_ok, lock_valid, game_over, busy;
    logic [XW-1:0] chk_x, x;
    logic [YW-1:0] chk_y, y;
    logic [2:0]    chk_type, ptype;
    logic [1:0]    chk_dir, dir;

    logic          g_start;
    logic          g_chk_valid, g_lock_valid, g_game_over, g_busy;
    logic [XW-1:0] g_chk_x, g_x;
    logic [YW-1:0] g_chk_y, g_y;
    logic [2:0]    g_chk_type, g_ptype;
    logic [1:0]    g_chk_dir, g_dir;

    int n_checks = 0;
    int n_fail   = 0;
    int lock_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (lock_valid) lock_cnt <= lock_cnt + 1;

    piece_ctrl #(
        .BOARD_W(10), .BOARD_H(20), .XW(XW), .YW(YW), .GRAV_DIV(1000), .SPAWN_X(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .left(left),
        .right(right), .drop(drop), .next_type(next_type), .chk_valid(chk_valid),
        .chk_x(chk_x), .chk_y(chk_y), .chk_type(chk_type), .chk_dir(chk_dir),
        .chk_ready(chk_ready), .chk_ok(chk_ok), .lock_valid(lock_valid), .x(x), .y(y),
        .ptype(ptype), .dir(dir), .game_over(game_over), .busy(busy)
    );

    piece_ctrl #(
        .BOARD_W(10), .BOARD_H(20), .XW(XW), .YW(YW), .GRAV_DIV(4), .SPAWN_X(4)
    ) gdut (
        .clk(clk), .rst(rst), .start(g_start), .up(1'b0), .down(1'b0), .left(1'b0),
        .right(1'b0), .drop(1'b0), .next_type(next_type), .chk_valid(g_chk_valid),
        .chk_x(g_chk_x), .chk_y(g_chk_y), .chk_type(g_chk_type), .chk_dir(g_chk_dir),
        .chk_ready(g_chk_valid), .chk_ok(1'b1), .lock_valid(g_lock_valid), .x(g_x), .y(g_y),
        .ptype(g_ptype), .dir(g_dir), .game_over(g_game_over), .busy(g_busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // 0 start, 1 up, 2 down, 3 left, 4 right, 5 drop
    task automatic press(input int b);
        @(negedge clk);
        case (b)
            0: start = 1'b1;
            1: up    = 1'b1;
            2: down  = 1'b1;
            3: left  = 1'b1;
            4: right = 1'b1;
            default: drop = 1'b1;
        endcase
        @(negedge clk);
        {start, up, down, left, right, drop} = '0;
    endtask

    task automatic respond(input bit ok, input int lat, output bit seen,
                           output logic [XW-1:0] cx, output logic [YW-1:0] cy,
                           output logic [2:0] ct, output logic [1:0] cd);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (chk_valid) seen = 1'b1;
            else @(negedge clk);
        end
        cx = chk_x; cy = chk_y; ct = chk_type; cd = chk_dir;
        repeat (lat) @(negedge clk);
        if (seen) begin
            chk_ready = 1'b1;
            chk_ok    = ok;
            @(negedge clk);
            chk_ready = 1'b0;
            chk_ok    = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {start, up, down, left, right, drop, g_start, chk_ready, chk_ok} = '0;
        next_type = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic spawn(input logic [2:0] t, output bit seen);
        logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        next_type = t;
        press(0);
        respond(1'b1, 0, seen, cx, cy, ct, cd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {start, up, down, left, right, drop, g_start, chk_ready, chk_ok} = '0;
        next_type = 3'd6;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({x, y, ptype, dir} !== '0) begin
            n_fail++; $display("FAIL reset_pos: got %h expected 0", {x, y, ptype, dir});
        end
        n_checks++;
        if ({lock_valid, chk_valid, game_over, busy, g_chk_valid, g_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0",
                     {lock_valid, chk_valid, game_over, busy, g_chk_valid, g_busy});
        end
        rst = 1'b0;
        // Reset landing during an open spawn check must drop the request.
        press(0);
        n_checks++;
        if (chk_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pre: chk_valid got %b expected 1", chk_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({chk_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid: chk_valid,busy got %b expected 00", {chk_valid, busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_spawn();
        bit seen; logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        do_reset();
        next_type = 3'd2;
        press(0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL spawn_busy: got %b expected 1", busy);
        end
        respond(1'b1, 1, seen, cx, cy, ct, cd);
        n_checks++;
        if ({seen, cx, cy, ct, cd} !== {1'b1, 5'd4, 5'd0, 3'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL spawn_cand: got seen=%b %0d,%0d,%0d,%0d expected 1 4,0,2,0",
                     seen, cx, cy, ct, cd);
        end
        n_checks++;
        if ({x, y, ptype, dir, busy} !== {5'd4, 5'd0, 3'd2, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL spawn_commit: got %0d,%0d,%0d,%0d busy=%b expected 4,0,2,0 busy=0",
                     x, y, ptype, dir, busy);
        end
    endtask

    task automatic test_moves();
        bit seen; logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        int base;
        do_reset();
        spawn(3'd0, seen);
        for (int i = 0; i < 4; i++) begin
            press(3);
            respond(1'b1, 0, seen, cx, cy, ct, cd);
        end
        n_checks++;
        if (x !== 5'd0) begin
            n_fail++; $display("FAIL left_to_wall: x got %0d expected 0", x);
        end
        press(3);
        n_checks++;
        if ({chk_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL left_wall_nochk: chk_valid,busy got %b expected 00",
                               {chk_valid, busy});
        end
        // A stray response with no request open must be ignored.
        chk_ready = 1'b1; chk_ok = 1'b1;
        @(negedge clk);
        chk_ready = 1'b0; chk_ok = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({x, y, dir, busy} !== '0) begin
            n_fail++; $display("FAIL stray_ready: x,y,dir,busy got %0d,%0d,%0d,%b expected 0,0,0,0",
                               x, y, dir, busy);
        end
        base = lock_cnt;
        press(4);
        respond(1'b0, 0, seen, cx, cy, ct, cd);
        @(negedge clk);
        n_checks++;
        if ({seen, cx, x, busy} !== {1'b1, 5'd1, 5'd0, 1'b0} || lock_cnt != base) begin
            n_fail++;
            $display("FAIL right_reject: seen=%b cand_x=%0d x=%0d busy=%b locks=%0d expected 1,1,0,0,0",
                     seen, cx, x, busy, lock_cnt - base);
        end
        for (int i = 0; i < 9; i++) begin
            press(4);
            respond(1'b1, 0, seen, cx, cy, ct, cd);
        end
        press(4);
        n_checks++;
        if ({x, chk_valid} !== {5'd9, 1'b0}) begin
            n_fail++; $display("FAIL right_wall: x=%0d chk_valid=%b expected 9,0", x, chk_valid);
        end
        press(1);
        respond(1'b1, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if ({x, y, dir} !== {5'd9, 5'd0, 2'd1}) begin
            n_fail++; $display("FAIL rotate: got %0d,%0d,%0d expected 9,0,1", x, y, dir);
        end
        press(2);
        respond(1'b1, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if (y !== 5'd1) begin
            n_fail++; $display("FAIL soft_drop: y got %0d expected 1", y);
        end
        base = lock_cnt;
        press(2);
        respond(1'b0, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if ({lock_valid, x, y, dir} !== {1'b1, 5'd9, 5'd1, 2'd1}) begin
            n_fail++; $display("FAIL down_lock: lock=%b %0d,%0d,%0d expected 1 9,1,1",
                               lock_valid, x, y, dir);
        end
        @(negedge clk);
        n_checks++;
        if ({lock_valid, chk_valid} !== 2'b01 || lock_cnt - base != 1) begin
            n_fail++; $display("FAIL down_lock_pulse: lock=%b chk=%b count=%0d expected 0,1,1",
                               lock_valid, chk_valid, lock_cnt - base);
        end
    endtask

    task automatic test_hard_drop();
        bit seen; logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        int base;
        do_reset();
        spawn(3'd5, seen);
        base = lock_cnt;
        press(5);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) left = 1'b1;
            respond(i < 7, 0, seen, cx, cy, ct, cd);
            left = 1'b0;
            n_checks++;
            if ({seen, cy} !== {1'b1, 5'(i + 1)}) begin
                n_fail++; $display("FAIL hd_cand_%0d: seen=%b y=%0d expected 1,%0d",
                                   i, seen, cy, i + 1);
            end
        end
        n_checks++;
        if ({lock_valid, x, y, ptype, dir} !== {1'b1, 5'd4, 5'd7, 3'd5, 2'd0}) begin
            n_fail++; $display("FAIL hd_lock: lock=%b %0d,%0d,%0d,%0d expected 1 4,7,5,0",
                               lock_valid, x, y, ptype, dir);
        end
        @(negedge clk);
        n_checks++;
        if ({lock_valid, chk_valid, chk_x, chk_y} !== {1'b0, 1'b1, 5'd4, 5'd0} ||
            lock_cnt - base != 1) begin
            n_fail++; $display("FAIL hd_respawn: lock=%b chk=%b %0d,%0d count=%0d expected 0,1 4,0 1",
                               lock_valid, chk_valid, chk_x, chk_y, lock_cnt - base);
        end
    endtask

    task automatic test_game_over();
        bit seen; logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        do_reset();
        next_type = 3'd3;
        press(0);
        respond(1'b0, 0, seen, cx, cy, ct, cd);
        @(negedge clk);
        n_checks++;
        if ({game_over, busy, chk_valid} !== 3'b100) begin
            n_fail++; $display("FAIL over: game_over,busy,chk got %b expected 100",
                               {game_over, busy, chk_valid});
        end
        press(0);
        n_checks++;
        if ({game_over, chk_valid, chk_x, chk_y, chk_dir} !== {1'b0, 1'b1, 5'd4, 5'd0, 2'd0}) begin
            n_fail++; $display("FAIL over_restart: go=%b chk=%b %0d,%0d,%0d expected 0,1 4,0,0",
                               game_over, chk_valid, chk_x, chk_y, chk_dir);
        end
        respond(1'b1, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if ({game_over, ptype, busy} !== {1'b0, 3'd3, 1'b0}) begin
            n_fail++; $display("FAIL over_respawn: go=%b type=%0d busy=%b expected 0,3,0",
                               game_over, ptype, busy);
        end
    endtask

    task automatic test_rotate_kick();
        bit seen; logic [XW-1:0] cx; logic [YW-1:0] cy; logic [2:0] ct; logic [1:0] cd;
        do_reset();
        spawn(3'd2, seen);
        press(4);
        respond(1'b1, 0, seen, cx, cy, ct, cd);
        press(1);
        respond(1'b0, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if ({seen, cx, cd} !== {1'b1, 5'd5, 2'd1}) begin
            n_fail++; $display("FAIL rot_first: seen=%b x=%0d dir=%0d expected 1,5,1", seen, cx, cd);
        end
`ifdef PIECE_WALLKICK_EN
        respond(1'b1, 0, seen, cx, cy, ct, cd);
        n_checks++;
        if ({seen, cx, cd} !== {1'b1, 5'd4, 2'd1}) begin
            n_fail++; $display("FAIL kick_cand: seen=%b x=%0d dir=%0d expected 1,4,1", seen, cx, cd);
        end
        n_checks++;
        if ({x, dir, busy} !== {5'd4, 2'd1, 1'b0}) begin
            n_fail++; $display("FAIL kick_commit: x=%0d dir=%0d busy=%b expected 4,1,0", x, dir, busy);
        end
`else
        n_checks++;
        if ({x, dir, chk_valid, busy} !== {5'd5, 2'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rot_discard: x=%0d dir=%0d chk=%b busy=%b expected 5,0,0,0",
                               x, dir, chk_valid, busy);
        end
`endif
    endtask

    task automatic test_gravity();
        logic [YW-1:0] prev;
        int cyc, changes;
        int ts[4];
        bit found;
        do_reset();
        @(negedge clk);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        prev = g_y; cyc = 0; changes = 0;
        while (changes < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (g_y != prev) begin
                ts[changes] = cyc;
                changes++;
                prev = g_y;
            end
        end
        n_checks++;
        if (changes != 4 || g_y !== 5'd4) begin
            n_fail++; $display("FAIL grav_steps: changes=%0d y=%0d expected 4,4", changes, g_y);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (ts[i] - ts[i-1] != 4) begin
                    n_fail++; $display("FAIL grav_period_%0d: got %0d expected 4", i, ts[i] - ts[i-1]);
                end
            end
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (g_lock_valid) found = 1'b1;
        end
        n_checks++;
        if ({found, g_x, g_y} !== {1'b1, 5'd4, 5'd19}) begin
            n_fail++; $display("FAIL grav_lock: found=%b x=%0d y=%0d expected 1,4,19", found, g_x, g_y);
        end
        @(negedge clk);
        n_checks++;
        if ({g_lock_valid, g_chk_valid, g_chk_y} !== {1'b0, 1'b1, 5'd0}) begin
            n_fail++; $display("FAIL grav_respawn: lock=%b chk=%b y=%0d expected 0,1,0",
                               g_lock_valid, g_chk_valid, g_chk_y);
        end
        @(negedge clk);
        n_checks++;
        if (g_y !== 5'd0) begin
            n_fail++; $display("FAIL grav_respawn_y: got %0d expected 0", g_y);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_moves();
        test_hard_drop();
        test_game_over();
        test_rotate_kick();
        test_gravity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
